// File: rtl/reverse_pkg.sv
// Shared definitions for the reverse-engine arbiter: the packet terminator
// byte and the arbiter FSM state type.
package reverse_pkg;

  localparam logic [7:0] TERM_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. When both requesters ask, the one that was not
// granted last wins; a lone requester always wins.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant
);

  // Pure combinational pick; the caller registers the winner.
  always_comb begin
    grant_valid = req0 | req1;
    if (req0 && req1) begin
      grant = ~last_grant;
    end else begin
      grant = req1;
    end
  end

endmodule

// File: rtl/reverse_arb.sv
// Arbiter sharing one byte-reversing engine between two requesters.
// A granted packet is streamed into the engine (FEED), then the reversed
// bytes are passed to the consumer (DRAIN) before the next arbitration.
// Optional build macro: REVERSE_ARB_TIMEOUT_EN enables a mid-packet stall
// watchdog that terminates a packet after TIMEOUT idle FEED cycles.
//
// Handshake semantics (all ports): a byte moves on a cycle where valid and
// ready are both high at the rising clock edge; valid never waits on ready,
// and the sender holds data stable until the transfer happens.
module reverse_arb #(
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req0_data,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req1_data,
  input  logic       req1_valid,
  output logic       req1_ready,
  output logic [7:0] eng_din,
  output logic       eng_din_valid,
  input  logic [7:0] eng_dout,
  input  logic       eng_ena,
  output logic       eng_rdy,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_src,
  input  logic       out_rdy,
  output logic [1:0] dbg_state
);

  import reverse_pkg::*;

  localparam int            CW      = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LEN);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  arb_state_e    state;
  logic [CW-1:0] cnt;
  logic          owner;
  logic          last_grant;
  logic          grant_valid;
  logic          grant;
  logic          g_valid;
  logic [7:0]    g_data;
  logic          stall_hit;
  logic          inject;
  logic          feed_open;
  logic          accept;
  logic          drain_hs;

  rr_arb2 u_rr (
    .req0        (req0_valid),
    .req1        (req1_valid),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // Select the granted requester's stream.
  always_comb begin
    g_valid = owner ? req1_valid : req0_valid;
    g_data  = owner ? req1_data  : req0_data;
  end

`ifdef REVERSE_ARB_TIMEOUT_EN
  localparam int            SW       = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STALL_MX = SW'(TIMEOUT);

  logic [SW-1:0] stall;

  // Count consecutive FEED cycles without an accepted byte.
  always_ff @(posedge clk) begin
    if (rst || (state != ST_FEED) || accept) begin
      stall <= '0;
    end else if (!stall_hit) begin
      stall <= stall + 1'b1;
    end
  end

  assign stall_hit = (stall == STALL_MX);
`else
  // Watchdog compiled out: FEED waits for the requester forever.
  assign stall_hit = (TIMEOUT < 0);
`endif

  // A terminator is forced into the engine on length overflow or stall.
  always_comb begin
    inject    = (state == ST_FEED) && ((cnt == CNT_MAX) || stall_hit);
    feed_open = (state == ST_FEED) && !inject;
    accept    = feed_open && g_valid;
    drain_hs  = (state == ST_DRAIN) && eng_ena && out_rdy;
  end

  // Port drive: zero-latency pass-through into and out of the engine.
  always_comb begin
    req0_ready    = feed_open && !owner;
    req1_ready    = feed_open && owner;
    eng_din_valid = inject || accept;
    if (inject) begin
      eng_din = TERM_BYTE;
    end else if (accept) begin
      eng_din = g_data;
    end else begin
      eng_din = 8'h00;
    end
    eng_rdy   = (state == ST_DRAIN) ? out_rdy : 1'b0;
    out_data  = eng_dout;
    out_valid = (state == ST_DRAIN) && eng_ena;
    out_src   = owner;
    dbg_state = state;
  end

  // Arbitration / feed / drain sequencing with the packet byte counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            owner <= grant;
            cnt   <= '0;
            state <= ST_FEED;
          end
        end
        ST_FEED: begin
          if (inject) begin
            state <= ST_DRAIN;
          end else if (accept) begin
            if (g_data == TERM_BYTE) begin
              state <= ST_DRAIN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          // An empty packet leaves immediately; otherwise count bytes out.
          if (cnt == '0) begin
            state      <= ST_IDLE;
            last_grant <= owner;
          end else if (drain_hs) begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_ONE) begin
              state      <= ST_IDLE;
              last_grant <= owner;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reverse_arb.sv
// Bench for reverse_arb: a stack-based reverse engine, a packet-level
// reference model with an expected-byte queue, directed packets per
// requester and literal checks on the observed output log.
module tb_reverse_arb;

  localparam int         MAX_LEN = 16;
  localparam int         TIMEOUT = 64;
  localparam logic [7:0] TERM    = 8'hFF;

  logic       clk;
  logic       rst;
  logic [7:0] req0_data, req1_data;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [7:0] eng_din;
  logic       eng_din_valid;
  logic [7:0] eng_dout;
  logic       eng_ena;
  logic       eng_rdy;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_src;
  logic       out_rdy;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  reverse_arb #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .req0_data     (req0_data),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req1_data     (req1_data),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .eng_din       (eng_din),
    .eng_din_valid (eng_din_valid),
    .eng_dout      (eng_dout),
    .eng_ena       (eng_ena),
    .eng_rdy       (eng_rdy),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_src       (out_src),
    .out_rdy       (out_rdy),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // ---------------- reverse engine model ----------------
  // LIFO: bytes collected until a terminator, then emitted last-in first.
  logic [7:0] eng_stack[$];
  bit         eng_emit;
  bit         cap_dv, cap_pop, cap_rst;
  logic [7:0] cap_d;

  initial begin
    eng_ena  = 1'b0;
    eng_dout = 8'h00;
    eng_emit = 1'b0;
    forever begin
      @(negedge clk);
      cap_dv  = eng_din_valid;
      cap_d   = eng_din;
      cap_pop = eng_ena && eng_rdy;
      cap_rst = rst;
      @(posedge clk);
      #1;
      if (cap_pop && eng_stack.size() > 0) void'(eng_stack.pop_front());
      if (cap_dv) begin
        if (cap_d == TERM) eng_emit = 1'b1;
        else eng_stack.push_front(cap_d);
      end
      if (cap_rst) begin
        eng_stack.delete();
        eng_emit = 1'b0;
      end
      if (eng_stack.size() == 0) eng_emit = 1'b0;
      eng_ena  = eng_emit;
      eng_dout = eng_emit ? eng_stack[0] : 8'h00;
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  typedef enum int {M_IDLE, M_FEED, M_DRAIN} m_phase_t;

  m_phase_t   m_phase = M_IDLE;
  int         m_owner = 0;
  int         m_last  = 1;
  int         m_stall = 0;
  logic [7:0] exp_q[$];     // front = next byte the consumer must see
  logic [8:0] out_log[$];   // observed {out_src, out_data} per transfer

  always @(negedge clk) begin : model
    logic       gv;
    logic [7:0] gd;
    logic [7:0] want;
    bit         trunc;
    if (rst) begin
      m_phase = M_IDLE;
      m_owner = 0;
      m_last  = 1;
      m_stall = 0;
      exp_q.delete();
    end else begin
      gv = (m_owner == 1) ? req1_valid : req0_valid;
      gd = (m_owner == 1) ? req1_data  : req0_data;
      check("out_src", out_src, m_owner);
      case (m_phase)
        M_IDLE: begin
          check("idle_req0_ready", req0_ready, 0);
          check("idle_req1_ready", req1_ready, 0);
          check("idle_eng_din_valid", eng_din_valid, 0);
          check("idle_out_valid", out_valid, 0);
          check("idle_eng_rdy", eng_rdy, 0);
          if (req0_valid || req1_valid) begin
            if (req0_valid && req1_valid) m_owner = 1 - m_last;
            else m_owner = req1_valid ? 1 : 0;
            m_phase = M_FEED;
            m_stall = 0;
            exp_q.delete();
          end
        end
        M_FEED: begin
          trunc = (exp_q.size() == MAX_LEN);
`ifdef REVERSE_ARB_TIMEOUT_EN
          if (m_stall == TIMEOUT) trunc = 1'b1;
`endif
          check("feed_req0_ready", req0_ready, (m_owner == 0) && !trunc);
          check("feed_req1_ready", req1_ready, (m_owner == 1) && !trunc);
          check("feed_out_valid", out_valid, 0);
          check("feed_eng_rdy", eng_rdy, 0);
          if (trunc) begin
            check("inject_valid", eng_din_valid, 1);
            check("inject_data", eng_din, TERM);
            m_phase = M_DRAIN;
          end else if (gv) begin
            check("feed_din_valid", eng_din_valid, 1);
            check("feed_din", eng_din, gd);
            m_stall = 0;
            if (gd == TERM) m_phase = M_DRAIN;
            else exp_q.push_front(gd);
          end else begin
            check("feed_din_idle", eng_din_valid, 0);
            m_stall++;
          end
        end
        default: begin
          check("drain_req0_ready", req0_ready, 0);
          check("drain_req1_ready", req1_ready, 0);
          check("drain_din_valid", eng_din_valid, 0);
          check("drain_eng_rdy", eng_rdy, out_rdy);
          check("drain_out_valid", out_valid, eng_ena);
          if (eng_ena && out_rdy) begin
            out_log.push_back({out_src, out_data});
            if (exp_q.size() == 0) begin
              bound_fail("drain_extra_output");
            end else begin
              want = exp_q.pop_front();
              check("drain_data", out_data, want);
            end
          end
          if (exp_q.size() == 0) begin
            m_phase = M_IDLE;
            m_last  = m_owner;
          end
        end
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int who, input logic v, input logic [7:0] d);
    if (who == 0) begin
      req0_valid = v;
      req0_data  = d;
    end else begin
      req1_valid = v;
      req1_data  = d;
    end
  endtask

  // Offer bytes one at a time; entered and left just after a rising edge.
  task automatic send_pkt(input int who, input logic [7:0] b[$], input int wait_max,
                          input bit strict, output int sent);
    int t;
    bit got;
    sent = 0;
    foreach (b[i]) begin
      set_req(who, 1'b1, b[i]);
      t   = 0;
      got = 1'b0;
      while (!got && t < wait_max) begin
        @(negedge clk);
        t++;
        got = (who == 0) ? req0_ready : req1_ready;
      end
      @(posedge clk);
      #1;
      if (got) begin
        sent++;
      end else begin
        if (strict) bound_fail("send_byte");
        break;
      end
    end
    set_req(who, 1'b0, 8'h00);
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (m_phase != M_IDLE && t < 300);
    if (m_phase != M_IDLE) bound_fail(name);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_log(input string name, input logic [8:0] exp[$]);
    check({name, "_count"}, out_log.size(), exp.size());
    foreach (exp[i]) begin
      if (i < out_log.size()) check({name, "_entry"}, out_log[i], exp[i]);
    end
    out_log.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_req(0, 1'b0, 8'h00);
    set_req(1, 1'b0, 8'h00);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    out_log.delete();
  endtask

  // ---------------- directed stimulus ----------------
  logic [7:0] pa[$];
  logic [7:0] pb[$];
  logic [8:0] el[$];
  int         n0, n1, t_wait;

  initial begin
    rst     = 1'b1;
    out_rdy = 1'b1;
    set_req(0, 1'b0, 8'h00);
    set_req(1, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_din_valid", eng_din_valid, 0);
    check("rst_eng_din", eng_din, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_eng_rdy", eng_rdy, 0);
    check("rst_out_src", out_src, 0);
    @(posedge clk);
    #1;

    // Single short packet from requester 0.
    pa = '{8'd17, TERM};
    send_pkt(0, pa, 50, 1'b1, n0);
    wait_idle("idle_single");
    el = '{9'h011};
    check_log("single", el);

    // Both requesters valid right after reset: requester 0 wins the tie.
    do_reset();
    pa = '{8'd18, 8'd19, 8'd20, TERM};
    pb = '{8'd5, TERM};
    fork
      send_pkt(0, pa, 200, 1'b1, n0);
      send_pkt(1, pb, 200, 1'b1, n1);
    join
    wait_idle("idle_tie");
    el = '{9'h014, 9'h013, 9'h012, 9'h105};
    check_log("tie", el);

    // Consumer stalls three cycles in the middle of a drain.
    pa = '{8'd1, 8'd2, 8'd3, 8'd4, TERM};
    fork
      send_pkt(0, pa, 50, 1'b1, n0);
      begin : stall_blk
        t_wait = 0;
        do begin
          @(negedge clk);
          t_wait++;
        end while (!(out_valid && out_rdy) && t_wait < 100);
        if (t_wait >= 100) bound_fail("wait_first_output");
        @(posedge clk);
        #1;
        out_rdy = 1'b0;
        @(negedge clk);
        check("stall_eng_rdy", eng_rdy, 0);
        check("stall_out_valid", out_valid, 1);
        repeat (3) begin
          @(posedge clk);
          #1;
        end
        out_rdy = 1'b1;
      end
    join
    wait_idle("idle_stall");
    el = '{9'h004, 9'h003, 9'h002, 9'h001};
    check_log("stall", el);

    // Over-long packet without terminator is truncated at MAX_LEN.
    pa.delete();
    for (int i = 0; i < 20; i++) pa.push_back(8'(100 + i));
    send_pkt(0, pa, 4, 1'b0, n0);
    check("trunc_sent", n0, 16);
    wait_idle("idle_trunc");
    el.delete();
    for (int i = 15; i >= 0; i--) el.push_back({1'b0, 8'(100 + i)});
    check_log("trunc", el);

    // Zero-length packet from requester 1: no output at all.
    pa = '{TERM};
    send_pkt(1, pa, 50, 1'b1, n1);
    wait_idle("idle_zero");
    el.delete();
    check_log("zero", el);

    // Reset in the middle of a packet from requester 1.
    set_req(1, 1'b1, 8'd9);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    set_req(1, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_req0_ready", req0_ready, 0);
    check("midrst_req1_ready", req1_ready, 0);
    check("midrst_din_valid", eng_din_valid, 0);
    check("midrst_eng_din", eng_din, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_eng_rdy", eng_rdy, 0);
    check("midrst_out_src", out_src, 0);
    check("midrst_out_data", out_data, 0);
    @(posedge clk);
    #1;
    out_log.delete();
    pa = '{8'd5, TERM};
    send_pkt(0, pa, 50, 1'b1, n0);
    wait_idle("idle_after_rst");
    el = '{9'h005};
    check_log("after_rst", el);

`ifdef REVERSE_ARB_TIMEOUT_EN
    // Requester stalls after one byte; the watchdog closes the packet.
    pa = '{8'd7};
    send_pkt(0, pa, 50, 1'b1, n0);
    wait_idle("idle_timeout");
    el = '{9'h007};
    check_log("timeout", el);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reverse_arb.md
REVERSE_ARB -- requirements
Module: reverse_arb

Interface
REQ-001 Parameter MAX_LEN, default 16, SHALL set the maximum data bytes per packet, excluding the terminator.
REQ-002 Parameter TIMEOUT, default 64, SHALL set the mid-packet stall limit in cycles (used only under REQ-024).
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit, SHALL be the reset, synchronous and active-high.
REQ-005 Ports req0_data / req1_data, input, 8 bits each, SHALL carry requester byte streams; 8'hFF is the terminator.
REQ-006 Ports req0_valid / req1_valid, input, 1 bit each, SHALL flag a valid requester byte.
REQ-007 Ports req0_ready / req1_ready, output, 1 bit each, SHALL flag arbiter acceptance; a byte transfers when valid && ready.
REQ-008 Ports eng_din, output, 8 bits, and eng_din_valid, output, 1 bit, SHALL drive the shared reverse engine input.
REQ-009 Ports eng_dout, input, 8 bits, and eng_ena, input, 1 bit, SHALL receive engine output bytes.
REQ-010 Port eng_rdy, output, 1 bit, SHALL be the back-pressure to the engine and equal out_rdy while in DRAIN, else 0.
REQ-011 Ports out_data, output, 8 bits, and out_valid, output, 1 bit, SHALL be eng_dout and eng_ena combinationally, with out_valid gated to 0 outside DRAIN.
REQ-012 Port out_src, output, 1 bit, SHALL give the index of the requester owning the packet being drained.
REQ-013 Port out_rdy, input, 1 bit, SHALL be the downstream consumer ready.

Function
REQ-014 The FSM SHALL have states IDLE, FEED and DRAIN.
REQ-015 IDLE: when any reqN_valid is high, the arbiter SHALL grant round-robin (requester not granted last wins ties) and move to FEED the next cycle; no byte is accepted in IDLE.
REQ-016 FEED: req_ready of the granted requester SHALL be 1 and the other 0; each accepted byte SHALL appear on eng_din with eng_din_valid=1 in the same cycle (zero latency).
REQ-017 FEED: a byte counter SHALL increment per accepted non-terminator byte; accepting 8'hFF SHALL move to DRAIN.
REQ-018 When the counter reaches MAX_LEN in FEED, the arbiter SHALL deassert req_ready, drive eng_din=8'hFF with eng_din_valid=1 for one cycle, and move to DRAIN (truncation).
REQ-019 A zero-length packet (first byte 8'hFF) SHALL pass the terminator and go from DRAIN to IDLE without any output handshake.
REQ-020 DRAIN: each eng_ena && out_rdy cycle SHALL decrement the counter; reaching zero SHALL return to IDLE and record the owner as last granted.
REQ-021 req_ready of the non-granted requester SHALL remain 0 until the next IDLE arbitration, even if it asserts valid.
REQ-022 Counter width SHALL be $clog2(MAX_LEN+1) bits; it shall never wrap.

Reset
REQ-023 On rst sampled high: state=IDLE, counter=0, all ready/valid outputs 0, eng_din=0, out_src=0, last granted=1 (so requester 0 wins the first tie); reset mid-FEED or mid-DRAIN SHALL abandon the packet.

Configuration
REQ-024 With REVERSE_ARB_TIMEOUT_EN defined, TIMEOUT consecutive FEED cycles with granted valid low SHALL inject 8'hFF as in REQ-018 and move to DRAIN; without it, FEED SHALL wait indefinitely and TIMEOUT is unused.

Structure
REQ-025 Package reverse_pkg SHALL hold TERM_BYTE=8'hFF and the state enum type.
REQ-026 Sub-module rr_arb2 SHALL implement the two-way round-robin grant with a last-grant input.

Verification
REQ-027 Req0 sends 17,FF with out_rdy=1 -> grant 0, eng_din 17 then FF, one output with out_src=0, then IDLE.
REQ-028 Both valid after reset, req0 = 18,19,20,FF and req1 = 5,FF -> req0 served first (3 outputs), then req1 (1 output, out_src=1).
REQ-029 out_rdy=0 for 3 cycles mid-DRAIN -> eng_rdy=0, counter held, no byte lost, drain completes after out_rdy returns.
REQ-030 Req0 sends 20 bytes with no FF, MAX_LEN=16 -> 16 accepted, injected FF, req0_ready=0 from that cycle, 16 outputs.
REQ-031 Req1 sends FF only -> DRAIN then IDLE with zero outputs; rst asserted mid-FEED -> IDLE and all outputs 0 next cycle.
REQ-032 With REVERSE_ARB_TIMEOUT_EN, req0 sends 7 then stalls 64 cycles -> FF injected, one output.
